// File: rtl/control_pkg.sv
// Shared types for the fetch/execute control sequencer: step states,
// opcode encodings and the opcode-class decode.
package control_pkg;

    localparam int unsigned OP_W = 5;

    typedef enum logic [3:0] {
        IDLE,
        T0,
        T1,
        T1W,
        T2,
        T3,
        T4,
        T5,
        T6,
        HALTED
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_MULDIV,
        CLS_NOP,
        CLS_HALT,
        CLS_ILLEGAL
    } op_class_e;

    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OP_W-1:0] OP_SHR  = 5'b00111;
    localparam logic [OP_W-1:0] OP_SHL  = 5'b01000;
    localparam logic [OP_W-1:0] OP_MUL  = 5'b01111;
    localparam logic [OP_W-1:0] OP_DIV  = 5'b10000;
    localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

    // Groups opcodes by the execute sequence they need.
    function automatic op_class_e op_class(input logic [OP_W-1:0] op);
        op_class_e cls;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL: cls = CLS_ALU;
            OP_MUL, OP_DIV:                                cls = CLS_MULDIV;
            OP_NOP:                                        cls = CLS_NOP;
            OP_HALT:                                       cls = CLS_HALT;
            default:                                       cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// Register index to one-hot select; all zero when disabled or the index
// names a register that does not exist.
module reg_select_decoder #(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned IDX_W    = 4
) (
    input  logic [IDX_W-1:0]    idx_i,
    input  logic                en_i,
    output logic [NUM_REGS-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            onehot_o[i] = en_i && (32'(idx_i) == i);
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/execute control-step generator for the bus DataPath: T0..T6 strobes,
// memory wait states with timeout, MUL/DIV two-word writeback, NOP/HALT.
module control_sequencer
    import control_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned OPCODE_W    = 5,
    parameter int unsigned REG_FIELD_W = 4,
    parameter int unsigned WAIT_LIMIT  = 15
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                start,
    input  logic                run,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   ir,
    output logic                pc_out,
    output logic                mar_in,
    output logic                inc_pc,
    output logic                z_in,
    output logic                z_low_out,
    output logic                z_high_out,
    output logic                pc_in,
    output logic                read,
    output logic                mdr_in,
    output logic                mdr_out,
    output logic                ir_in,
    output logic                y_in,
    output logic                hi_in,
    output logic                lo_in,
    output logic [NUM_REGS-1:0] rin,
    output logic [NUM_REGS-1:0] rout,
    output logic [OPCODE_W-1:0] alu_op,
    output logic                busy,
    output logic                done,
    output logic                halted,
    output logic                error
);

    localparam int unsigned CNT_W = $clog2(WAIT_LIMIT + 1);
    localparam int unsigned RA_HI = DATA_W - OPCODE_W - 1;
    localparam int unsigned RB_HI = RA_HI - REG_FIELD_W;
    localparam int unsigned RC_HI = RB_HI - REG_FIELD_W;
    localparam int unsigned LOW_W = DATA_W - OPCODE_W - 3 * REG_FIELD_W;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [OPCODE_W-1:0]    opcode;
    logic [REG_FIELD_W-1:0] ra, rb, rc;
    logic [REG_FIELD_W-1:0] rout_idx;
    op_class_e              op_cls;
    logic                   ra_ok, rb_ok, rc_ok, legal;
    logic                   rin_en, rout_en;

    assign opcode = ir[DATA_W-1 -: OPCODE_W];
    assign ra     = ir[RA_HI -: REG_FIELD_W];
    assign rb     = ir[RB_HI -: REG_FIELD_W];
    assign rc     = ir[RC_HI -: REG_FIELD_W];
    assign op_cls = op_class(OP_W'(opcode));

    assign ra_ok = 32'(ra) < NUM_REGS;
    assign rb_ok = 32'(rb) < NUM_REGS;
    assign rc_ok = 32'(rc) < NUM_REGS;
    // MUL/DIV write HI/LO rather than Ra, so Ra is not range-checked for them.
    assign legal = ((op_cls == CLS_ALU) && ra_ok && rb_ok && rc_ok) ||
                   ((op_cls == CLS_MULDIV) && rb_ok && rc_ok);

    generate
        if (LOW_W > 0) begin : g_ir_low
            logic unused_ir_low;
            assign unused_ir_low = ^ir[LOW_W-1:0];
        end
    endgenerate

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        pc_out     = 1'b0;
        mar_in     = 1'b0;
        inc_pc     = 1'b0;
        z_in       = 1'b0;
        z_low_out  = 1'b0;
        z_high_out = 1'b0;
        pc_in      = 1'b0;
        read       = 1'b0;
        mdr_in     = 1'b0;
        mdr_out    = 1'b0;
        ir_in      = 1'b0;
        y_in       = 1'b0;
        hi_in      = 1'b0;
        lo_in      = 1'b0;
        alu_op     = '0;
        rin_en     = 1'b0;
        rout_en    = 1'b0;
        rout_idx   = rb;
        busy       = 1'b1;
        done       = 1'b0;
        halted     = 1'b0;
        error      = 1'b0;

        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) state_d = T0;
            end
            T0: begin
                pc_out  = 1'b1;
                mar_in  = 1'b1;
                inc_pc  = 1'b1;
                z_in    = 1'b1;
                state_d = T1;
            end
            T1: begin
                z_low_out = 1'b1;
                pc_in     = 1'b1;
                read      = 1'b1;
                mdr_in    = 1'b1;
                state_d   = mem_ready ? T2 : T1W;
            end
            // cnt_q holds the number of wait cycles already spent here.
            T1W: begin
                read   = 1'b1;
                mdr_in = 1'b1;
                cnt_d  = cnt_q + CNT_W'(1);
                if (mem_ready) begin
                    state_d = T2;
                end else if (cnt_q == CNT_W'(WAIT_LIMIT - 1)) begin
                    error   = 1'b1;
                    state_d = IDLE;
                end
            end
            T2: begin
                mdr_out = 1'b1;
                ir_in   = 1'b1;
                state_d = T3;
            end
            T3: begin
                if (legal) begin
                    rout_en = 1'b1;
                    y_in    = 1'b1;
                    state_d = T4;
                end else if (op_cls == CLS_NOP) begin
                    done    = 1'b1;
                    state_d = run ? T0 : IDLE;
                end else if (op_cls == CLS_HALT) begin
                    done    = 1'b1;
                    state_d = HALTED;
                end else begin
                    error   = 1'b1;
                    state_d = IDLE;
                end
            end
            T4: begin
                rout_en  = 1'b1;
                rout_idx = rc;
                alu_op   = opcode;
                z_in     = 1'b1;
                state_d  = T5;
            end
            T5: begin
                z_low_out = 1'b1;
                if (op_cls == CLS_MULDIV) begin
                    lo_in   = 1'b1;
                    state_d = T6;
                end else begin
                    rin_en  = 1'b1;
                    done    = 1'b1;
                    state_d = run ? T0 : IDLE;
                end
            end
            T6: begin
                z_high_out = 1'b1;
                hi_in      = 1'b1;
                done       = 1'b1;
                state_d    = run ? T0 : IDLE;
            end
            HALTED: begin
                busy   = 1'b0;
                halted = 1'b1;
            end
            default: begin
                busy    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    reg_select_decoder #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (REG_FIELD_W)
    ) u_rin_dec (
        .idx_i    (ra),
        .en_i     (rin_en),
        .onehot_o (rin)
    );

    reg_select_decoder #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (REG_FIELD_W)
    ) u_rout_dec (
        .idx_i    (rout_idx),
        .en_i     (rout_en),
        .onehot_o (rout)
    );

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-cycle expected output vectors are
// queued ahead of each instruction and checked cycle by cycle.
module tb_control_sequencer;

    typedef struct packed {
        logic [13:0] strb;
        logic [15:0] rin;
        logic [15:0] rout;
        logic [4:0]  alu_op;
        logic        busy;
        logic        done;
        logic        halted;
        logic        error;
    } obs_t;

    localparam logic [13:0] PC_OUT  = 14'h2000;
    localparam logic [13:0] MAR_IN  = 14'h1000;
    localparam logic [13:0] INC_PC  = 14'h0800;
    localparam logic [13:0] Z_IN    = 14'h0400;
    localparam logic [13:0] Z_LOW   = 14'h0200;
    localparam logic [13:0] Z_HIGH  = 14'h0100;
    localparam logic [13:0] PC_IN   = 14'h0080;
    localparam logic [13:0] READ    = 14'h0040;
    localparam logic [13:0] MDR_IN  = 14'h0020;
    localparam logic [13:0] MDR_OUT = 14'h0010;
    localparam logic [13:0] IR_IN   = 14'h0008;
    localparam logic [13:0] Y_IN    = 14'h0004;
    localparam logic [13:0] HI_IN   = 14'h0002;
    localparam logic [13:0] LO_IN   = 14'h0001;

    localparam logic [4:0] ADD  = 5'b00011;
    localparam logic [4:0] MUL  = 5'b01111;
    localparam logic [4:0] NOP  = 5'b11010;
    localparam logic [4:0] HALT = 5'b11011;
    localparam logic [4:0] BAD  = 5'b11111;

    logic        clock = 1'b0;
    logic        clear, start, run, mem_ready;
    logic [31:0] ir, ir8;
    logic [13:0] s, s8;
    logic [15:0] rin, rout;
    logic [7:0]  rin8, rout8;
    logic [4:0]  alu_op, alu_op8;
    logic        busy, done, halted, error;
    logic        busy8, done8, halted8, error8;

    int n_tests = 0;
    int n_fail  = 0;

    obs_t exp_q[$];
    obs_t exp8_q[$];
    obs_t v_idle, v_t0, v_t1, v_t1w, v_t2, v_halt;
    obs_t v_add3, v_add4, v_add5;

    always #5 clock = ~clock;

    control_sequencer dut (
        .clock(clock), .clear(clear), .start(start), .run(run),
        .mem_ready(mem_ready), .ir(ir),
        .pc_out(s[13]), .mar_in(s[12]), .inc_pc(s[11]), .z_in(s[10]),
        .z_low_out(s[9]), .z_high_out(s[8]), .pc_in(s[7]), .read(s[6]),
        .mdr_in(s[5]), .mdr_out(s[4]), .ir_in(s[3]), .y_in(s[2]),
        .hi_in(s[1]), .lo_in(s[0]),
        .rin(rin), .rout(rout), .alu_op(alu_op),
        .busy(busy), .done(done), .halted(halted), .error(error)
    );

    control_sequencer #(.NUM_REGS(8)) dut8 (
        .clock(clock), .clear(clear), .start(start), .run(run),
        .mem_ready(mem_ready), .ir(ir8),
        .pc_out(s8[13]), .mar_in(s8[12]), .inc_pc(s8[11]), .z_in(s8[10]),
        .z_low_out(s8[9]), .z_high_out(s8[8]), .pc_in(s8[7]), .read(s8[6]),
        .mdr_in(s8[5]), .mdr_out(s8[4]), .ir_in(s8[3]), .y_in(s8[2]),
        .hi_in(s8[1]), .lo_in(s8[0]),
        .rin(rin8), .rout(rout8), .alu_op(alu_op8),
        .busy(busy8), .done(done8), .halted(halted8), .error(error8)
    );

    function automatic obs_t mk(input logic [13:0] st, input logic [15:0] ri,
                                input logic [15:0] ro, input logic [4:0] op,
                                input logic b, input logic d, input logic h,
                                input logic e);
        obs_t o;
        o.strb = st; o.rin = ri; o.rout = ro; o.alu_op = op;
        o.busy = b; o.done = d; o.halted = h; o.error = e;
        return o;
    endfunction

    function automatic logic [31:0] enc(input logic [4:0] op, input logic [3:0] a,
                                        input logic [3:0] b, input logic [3:0] c);
        return {op, a, b, c, 15'h2a5a};
    endfunction

    function automatic obs_t get_obs();
        return mk(s, rin, rout, alu_op, busy, done, halted, error);
    endfunction

    function automatic obs_t get_obs8();
        return mk(s8, {8'h00, rin8}, {8'h00, rout8}, alu_op8, busy8, done8, halted8, error8);
    endfunction

    task automatic chk(input string tag);
        obs_t got, e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = get_obs();
            n_tests++;
            assert (got === e) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", tag, got, e);
            end
        end
        if (exp8_q.size() > 0) begin
            e = exp8_q.pop_front();
            got = get_obs8();
            n_tests++;
            assert (got === e) else begin
                n_fail++;
                $error("FAIL %s_nr8: observed %h expected %h", tag, got, e);
            end
        end
    endtask

    task automatic step(input logic st, input logic mr, input logic rn, input string tag);
        @(posedge clock);
        #1;
        start = st; mem_ready = mr; run = rn;
        #1;
        chk(tag);
    endtask

    task automatic push_fetch();
        exp_q.push_back(v_t0);
        exp_q.push_back(v_t1);
        exp_q.push_back(v_t2);
    endtask

    task automatic push_add_exec();
        exp_q.push_back(v_add3);
        exp_q.push_back(v_add4);
        exp_q.push_back(v_add5);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        v_idle = mk(14'h0, 16'h0, 16'h0, 5'h0, 0, 0, 0, 0);
        v_t0   = mk(PC_OUT | MAR_IN | INC_PC | Z_IN, 16'h0, 16'h0, 5'h0, 1, 0, 0, 0);
        v_t1   = mk(Z_LOW | PC_IN | READ | MDR_IN, 16'h0, 16'h0, 5'h0, 1, 0, 0, 0);
        v_t1w  = mk(READ | MDR_IN, 16'h0, 16'h0, 5'h0, 1, 0, 0, 0);
        v_t2   = mk(MDR_OUT | IR_IN, 16'h0, 16'h0, 5'h0, 1, 0, 0, 0);
        v_halt = mk(14'h0, 16'h0, 16'h0, 5'h0, 0, 0, 1, 0);
        // ADD R4,R3,R7: Rb drives at T3, Rc at T4, Ra loads at T5.
        v_add3 = mk(Y_IN, 16'h0, 16'h0008, 5'h0, 1, 0, 0, 0);
        v_add4 = mk(Z_IN, 16'h0, 16'h0080, 5'd3, 1, 0, 0, 0);
        v_add5 = mk(Z_LOW, 16'h0010, 16'h0, 5'h0, 1, 1, 0, 0);

        clear = 1'b0; start = 1'b1; run = 1'b0; mem_ready = 1'b1;
        ir  = enc(ADD, 4'd4, 4'd3, 4'd7);
        ir8 = enc(ADD, 4'd9, 4'd3, 4'd7);

        // Held in reset: start has no effect.
        exp_q.push_back(v_idle); exp_q.push_back(v_idle);
        step(1, 1, 0, "reset");
        step(1, 1, 0, "reset");
        start = 1'b0;
        clear = 1'b1;

        // ADD R4,R3,R7 with no wait states, run=0.
        exp_q.push_back(v_idle); push_fetch(); push_add_exec();
        exp_q.push_back(v_idle); exp_q.push_back(v_idle);
        step(1, 1, 0, "add");
        repeat (8) step(0, 1, 0, "add");

        // MUL R0,R6,R7 on the main DUT; Ra=9 out of range on the 8-register DUT.
        ir = enc(MUL, 4'd0, 4'd6, 4'd7);
        exp_q.push_back(v_idle); push_fetch();
        exp_q.push_back(mk(Y_IN, 16'h0, 16'h0040, 5'h0, 1, 0, 0, 0));
        exp_q.push_back(mk(Z_IN, 16'h0, 16'h0080, 5'h0f, 1, 0, 0, 0));
        exp_q.push_back(mk(Z_LOW | LO_IN, 16'h0, 16'h0, 5'h0, 1, 0, 0, 0));
        exp_q.push_back(mk(Z_HIGH | HI_IN, 16'h0, 16'h0, 5'h0, 1, 1, 0, 0));
        exp_q.push_back(v_idle);
        exp8_q.push_back(v_idle);
        exp8_q.push_back(v_t0); exp8_q.push_back(v_t1); exp8_q.push_back(v_t2);
        exp8_q.push_back(mk(14'h0, 16'h0, 16'h0, 5'h0, 1, 0, 0, 1));
        repeat (4) exp8_q.push_back(v_idle);
        step(1, 1, 0, "mul");
        repeat (8) step(0, 1, 0, "mul");

        // Three wait cycles before read data arrives.
        ir = enc(ADD, 4'd4, 4'd3, 4'd7);
        exp_q.push_back(v_idle); exp_q.push_back(v_t0); exp_q.push_back(v_t1);
        repeat (3) exp_q.push_back(v_t1w);
        exp_q.push_back(v_t2); push_add_exec(); exp_q.push_back(v_idle);
        step(1, 0, 0, "wait3");
        step(0, 0, 0, "wait3");
        step(0, 0, 0, "wait3");
        step(0, 0, 0, "wait3");
        step(0, 0, 0, "wait3");
        step(0, 1, 0, "wait3");
        repeat (5) step(0, 1, 0, "wait3");

        // mem_ready on the last allowed wait cycle still completes the fetch.
        exp_q.push_back(v_idle); exp_q.push_back(v_t0); exp_q.push_back(v_t1);
        repeat (15) exp_q.push_back(v_t1w);
        exp_q.push_back(v_t2); push_add_exec(); exp_q.push_back(v_idle);
        step(1, 0, 0, "wait_lim");
        step(0, 0, 0, "wait_lim");
        step(0, 0, 0, "wait_lim");
        repeat (14) step(0, 0, 0, "wait_lim");
        step(0, 1, 0, "wait_lim");
        repeat (5) step(0, 1, 0, "wait_lim");

        // No mem_ready at all: error on the 15th wait cycle, then idle.
        exp_q.push_back(v_idle); exp_q.push_back(v_t0); exp_q.push_back(v_t1);
        repeat (14) exp_q.push_back(v_t1w);
        exp_q.push_back(mk(READ | MDR_IN, 16'h0, 16'h0, 5'h0, 1, 0, 0, 1));
        exp_q.push_back(v_idle);
        step(1, 0, 0, "timeout");
        repeat (17) step(0, 0, 0, "timeout");
        step(0, 1, 0, "timeout");

        // Unknown opcode.
        ir = enc(BAD, 4'd1, 4'd2, 4'd3);
        exp_q.push_back(v_idle); push_fetch();
        exp_q.push_back(mk(14'h0, 16'h0, 16'h0, 5'h0, 1, 0, 0, 1));
        exp_q.push_back(v_idle);
        step(1, 1, 0, "illegal_op");
        repeat (5) step(0, 1, 0, "illegal_op");

        // run=1 chain: NOP, ADD, HALT back to back, then start is ignored.
        ir = enc(NOP, 4'd0, 4'd0, 4'd0);
        exp_q.push_back(v_idle); push_fetch();
        exp_q.push_back(mk(14'h0, 16'h0, 16'h0, 5'h0, 1, 1, 0, 0));
        push_fetch(); push_add_exec();
        push_fetch();
        exp_q.push_back(mk(14'h0, 16'h0, 16'h0, 5'h0, 1, 1, 0, 0));
        repeat (3) exp_q.push_back(v_halt);
        step(1, 1, 1, "chain");
        repeat (4) step(0, 1, 1, "chain");
        step(1, 1, 1, "chain");
        ir = enc(ADD, 4'd4, 4'd3, 4'd7);
        repeat (5) step(0, 1, 1, "chain");
        step(1, 1, 1, "chain");
        ir = enc(HALT, 4'd0, 4'd0, 4'd0);
        repeat (3) step(0, 1, 1, "chain");
        repeat (3) step(1, 1, 1, "halted");

        // Clear leaves HALTED immediately.
        clear = 1'b0;
        exp_q.push_back(v_idle);
        #1 chk("clr_halt");
        exp_q.push_back(v_idle);
        step(1, 1, 0, "clr_held");
        start = 1'b0;
        clear = 1'b1;

        // Clear in the middle of T4 kills every strobe at once.
        ir = enc(ADD, 4'd4, 4'd3, 4'd7);
        exp_q.push_back(v_idle); push_fetch();
        exp_q.push_back(v_add3); exp_q.push_back(v_add4);
        step(1, 1, 0, "clr_t4");
        repeat (5) step(0, 1, 0, "clr_t4");
        clear = 1'b0;
        exp_q.push_back(v_idle);
        #1 chk("clr_mid_t4");
        exp_q.push_back(v_idle);
        step(0, 1, 0, "clr_mid_t4");
        clear = 1'b1;

        // Clean rerun after the abort.
        exp_q.push_back(v_idle); push_fetch(); push_add_exec();
        exp_q.push_back(v_idle); exp_q.push_back(v_idle);
        step(1, 1, 0, "rerun");
        repeat (8) step(0, 1, 0, "rerun");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
